reg_transfer_sequencer: RTL and testbench



---
 rtl/rt_pkg.sv | 35 +++
 rtl/rt_incdec.sv | 27 ++
 rtl/reg_transfer_sequencer.sv | 89 ++++++++
 tb/tb_reg_transfer_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared encodings for the register-transfer sequencer: opcodes, FSM states,
// register indices and opcode field positions.
package rt_pkg;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_LDI = 2'b01,
    OP_INC = 2'b10,
    OP_DEC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_IMM   = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] SP = 3'd5;
  localparam logic [2:0] MD = 3'd6;
  localparam logic [2:0] MA = 3'd7;

  localparam int OP_HI = 7;
  localparam int OP_LO = 6;
  localparam int RD_HI = 5;
  localparam int RD_LO = 3;
  localparam int RS_HI = 2;
  localparam int RS_LO = 0;

endpackage

// File: rtl/rt_incdec.sv
// Combinational pass/increment/decrement unit; carry flags the wrap on INC
// (FF->00) and the borrow on DEC (00->FF).
module rt_incdec
  import rt_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  op_e                   op_i,
  output logic [DATA_WIDTH-1:0] y_o,
  output logic                  carry_o
);

  always_comb begin
    y_o     = a_i;
    carry_o = 1'b0;
    case (op_i)
      OP_INC: {carry_o, y_o} = {1'b0, a_i} + {{DATA_WIDTH{1'b0}}, 1'b1};
      OP_DEC: begin
        y_o     = a_i - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        carry_o = (a_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Decodes a byte stream of register-transfer instructions and drives the
// register file write/read ports, tracking Z/C flags for downstream stages.
module reg_transfer_sequencer
  import rt_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic [DATA_WIDTH-1:0] instrData,
  input  logic                  instrValid,
  output logic                  instrReady,
  output logic [DATA_WIDTH-1:0] rfDataIn,
  output logic [SEL_WIDTH-1:0]  rfWriteSelect,
  output logic                  rfWriteEnable,
  output logic [SEL_WIDTH-1:0]  rfReadSelect,
  input  logic [DATA_WIDTH-1:0] rfDataOut,
  output logic                  busy,
  output logic                  done,
  output logic                  flagZ,
  output logic                  flagC
);

  state_e                  state_q;
  op_e                     op_q;
  logic [SEL_WIDTH-1:0]    rd_q, rs_q;
  logic [DATA_WIDTH-1:0]   imm_q;
  logic                    done_q, flag_z_q, flag_c_q;

  logic                    xfer, in_exec, in_write, wr;
  logic [DATA_WIDTH-1:0]   alu_y;
  logic                    alu_c;

  assign in_exec    = (state_q == ST_EXEC);
  assign in_write   = (state_q == ST_WRITE);
  assign wr         = in_exec | in_write;
  assign instrReady = (state_q == ST_IDLE) | (state_q == ST_IMM);
  assign xfer       = instrValid & instrReady;
  assign busy       = (state_q != ST_IDLE);

  // Write-side outputs decode straight from state so reset kills the strobe at once.
  assign rfWriteEnable = wr;
  assign rfWriteSelect = wr ? rd_q : '0;
  assign rfReadSelect  = in_exec ? ((op_q == OP_MOV) ? rs_q : rd_q) : '0;
  assign rfDataIn      = in_exec ? alu_y : (in_write ? imm_q : '0);

  rt_incdec #(.DATA_WIDTH(DATA_WIDTH)) u_incdec (
    .a_i     (rfDataOut),
    .op_i    (op_q),
    .y_o     (alu_y),
    .carry_o (alu_c)
  );

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MOV;
      rd_q     <= '0;
      rs_q     <= '0;
      imm_q    <= '0;
      done_q   <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      done_q <= wr;
      case (state_q)
        ST_IDLE: if (xfer) begin
          op_q    <= op_e'(instrData[OP_HI:OP_LO]);
          rd_q    <= instrData[RD_HI:RD_LO];
          rs_q    <= instrData[RS_HI:RS_LO];
          state_q <= (op_e'(instrData[OP_HI:OP_LO]) == OP_LDI) ? ST_IMM : ST_EXEC;
        end
        ST_IMM: if (xfer) begin
          imm_q   <= instrData;
          state_q <= ST_WRITE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (wr) flag_z_q <= (rfDataIn == '0);
      if (in_exec && (op_q == OP_INC || op_q == OP_DEC)) flag_c_q <= alu_c;
    end
  end

  assign done  = done_q;
  assign flagZ = flag_z_q;
  assign flagC = flag_c_q;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Randomized scoreboard bench for reg_transfer_sequencer with a behavioural
// register-file reference model and an attached register-file model.
module tb_reg_transfer_sequencer;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic [7:0] instrData = 8'h00;
  logic       instrValid = 1'b0;
  logic       instrReady, rfWriteEnable, busy, done, flagZ, flagC;
  logic [7:0] rfDataIn, rfDataOut;
  logic [2:0] rfWriteSelect, rfReadSelect;

  reg_transfer_sequencer #(.DATA_WIDTH(8), .SEL_WIDTH(3)) dut (
    .clk(clk), .clear_n(clear_n), .instrData(instrData), .instrValid(instrValid),
    .instrReady(instrReady), .rfDataIn(rfDataIn), .rfWriteSelect(rfWriteSelect),
    .rfWriteEnable(rfWriteEnable), .rfReadSelect(rfReadSelect), .rfDataOut(rfDataOut),
    .busy(busy), .done(done), .flagZ(flagZ), .flagC(flagC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [2:0] rsel;
    logic [7:0] data;
    logic       z;
    logic       c;
    int         acc;
  } exp_t;

  exp_t wq[$];
  exp_t fq[$];
  int   checks = 0, errors = 0, cyc = 0, nwrites = 0;
  bit   prev_we = 1'b0;
  logic [7:0] rf[8]     = '{default: 8'h00};
  logic [7:0] ref_rf[8] = '{default: 8'h00};
  bit   mz = 1'b0, mc = 1'b0;

  assign rfDataOut = rf[rfReadSelect];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rfWriteEnable) rf[rfWriteSelect] <= rfDataIn;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: pops expected writes on each strobe, expected flags on each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (clear_n) begin
      chk("done_after_write", done, prev_we);
      if (done) begin
        if (fq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = fq.pop_front();
          chk("flagZ", flagZ, e.z);
          chk("flagC", flagC, e.c);
        end
      end
      if (rfWriteEnable) begin
        nwrites++;
        chk("we_consecutive", prev_we, 0);
        chk("ready_during_write", instrReady, 0);
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = wq.pop_front();
          chk("write_sel", rfWriteSelect, e.sel);
          chk("write_data", rfDataIn, e.data);
          chk("read_sel", rfReadSelect, e.rsel);
          chk("latency", cyc, e.acc + 1);
          fq.push_back(e);
        end
      end else begin
        chk("idle_wsel", rfWriteSelect, 0);
        chk("idle_data", rfDataIn, 0);
        chk("idle_rsel", rfReadSelect, 0);
      end
      prev_we = rfWriteEnable;
    end else prev_we = 1'b0;
  end

  task automatic idle(input int n);
    instrValid = 1'b0;
    instrData  = 8'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, output int acc);
    int n = 0;
    bit r;
    instrValid = 1'b1;
    instrData  = b;
    do begin
      @(negedge clk);
      r = instrReady;
      acc = cyc;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 100);
    if (!r) chk("send_timeout", 0, 1);
  endtask

  task automatic instr(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [7:0] imm, input int pre_gap, input int imm_gap);
    int acc;
    exp_t e;
    logic [7:0] v, src;
    logic c;
    logic [2:0] rsel;
    if (pre_gap > 0) idle(pre_gap);
    send({op, rd, rs}, acc);
    if (op == 2'b01) begin
      if (imm_gap > 0) idle(imm_gap);
      send(imm, acc);
    end
    c = mc;
    rsel = 3'd0;
    case (op)
      2'b00: begin v = ref_rf[rs]; rsel = rs; end
      2'b01: v = imm;
      2'b10: begin src = ref_rf[rd]; v = src + 8'd1; c = (src == 8'hFF); rsel = rd; end
      default: begin src = ref_rf[rd]; v = src - 8'd1; c = (src == 8'h00); rsel = rd; end
    endcase
    ref_rf[rd] = v;
    mz = (v == 8'h00);
    mc = c;
    e = '{rd, rsel, v, mz, mc, acc};
    wq.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    instrValid = 1'b0;
    while ((wq.size() != 0 || fq.size() != 0) && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_pending", wq.size() + fq.size(), 0);
  endtask

  task automatic cmp_rf(input string nm);
    for (int i = 0; i < 8; i++) chk(nm, rf[i], ref_rf[i]);
  endtask

  initial begin
    #1000000;
    chk("watchdog", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int acc, n0;
    logic [7:0] imm;
    #12;
    chk("rst_we", rfWriteEnable, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {flagZ, flagC}, 0);
    @(negedge clk);
    clear_n = 1'b1;
    #1;
    chk("rst_ready", instrReady, 1);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;

    instr(2'b01, 3'd1, 3'd2, 8'h5C, 0, 3);     // LDI R1,0x5C with IMM gap
    instr(2'b00, 3'd3, 3'd1, 8'h00, 1, 0);     // MOV R3,R1
    drain();
    chk("mov_r3", rf[3], 8'h5C);
    instr(2'b01, 3'd2, 3'd0, 8'hFF, 0, 0);
    instr(2'b10, 3'd2, 3'd0, 8'h00, 0, 0);     // INC R2 wraps
    instr(2'b11, 3'd2, 3'd0, 8'h00, 2, 0);     // DEC R2 borrows
    drain();
    chk("dec_r2", rf[2], 8'hFF);

    n0 = nwrites;
    instr(2'b01, 3'd4, 3'd0, 8'h33, 0, 0);
    instr(2'b00, 3'd0, 3'd4, 8'h00, 0, 0);
    instr(2'b10, 3'd0, 3'd0, 8'h00, 0, 0);
    instr(2'b11, 3'd4, 3'd0, 8'h00, 0, 0);
    drain();
    chk("b2b_writes", nwrites - n0, 4);
    cmp_rf("b2b_rf");

    // Reset in the middle of an INC: strobe must drop without the write landing.
    send(8'h88, acc);
    chk("exec_we", rfWriteEnable, 1);
    #1;
    clear_n = 1'b0;
    #1;
    chk("midrst_we", rfWriteEnable, 0);
    chk("midrst_flags", {flagZ, flagC}, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rsel", rfReadSelect, 0);
    instrValid = 1'b0;
    mz = 1'b0;
    mc = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    #1;
    chk("post_rst_ready", instrReady, 1);
    chk("post_rst_done", done, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: imm = 8'h00;
        1: imm = 8'hFF;
        default: imm = 8'($urandom);
      endcase
      instr(2'($urandom), 3'($urandom), 3'($urandom), imm,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    drain();
    cmp_rf("final_rf");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
